// File: rtl/if_id_hazard_controller_pkg.sv
// Shared control types for the IF/ID hazard sequencing logic.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        FLUSH,
        MEM_WAIT
    } hazard_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/if_id_hazard_controller_if.sv
// Decode-side hazard inputs and IF/PC/IF-ID control outputs of the hazard controller.
interface if_id_hazard_controller_if #(
    parameter int reg_bits = 5,
    parameter int cnt_bits = 16
);
    logic [reg_bits-1:0] id_rs1;
    logic [reg_bits-1:0] id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic [reg_bits-1:0] ex_rd;
    logic                ex_mem_read;
    logic                ex_branch_taken;
    logic                imem_ready;

    logic                pc_write_enable;
    logic                pc_write_id_enable;
    logic                flush_pc_enable;
    logic                flush_adder_enable;
    logic                id_ex_bubble;
    logic                busy;
    logic [cnt_bits-1:0] stall_count;
    logic [cnt_bits-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready,
        input  pc_write_enable, pc_write_id_enable, flush_pc_enable,
               flush_adder_enable, id_ex_bubble, busy, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, imem_ready,
        output pc_write_enable, pc_write_id_enable, flush_pc_enable,
               flush_adder_enable, id_ex_bubble, busy, stall_count, flush_count
    );
endinterface

// File: rtl/if_id_hazard_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/if_id_hazard_controller.sv
// IF-stage / IF-ID register sequencer: load-use stalls, branch flushes, imem wait states,
// plus saturating stall/flush performance counters.
module if_id_hazard_controller
    import core_ctrl_pkg::*;
#(
    parameter int data_bits         = 32,
    parameter int reg_bits          = 5,
    parameter int load_stall_cycles = 1,
    parameter int flush_cycles      = 1,
    parameter int cnt_bits          = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    if_id_hazard_controller_if.slave hz
);

    if (data_bits < 32 || reg_bits < 1 || cnt_bits < 1 ||
        load_stall_cycles < 1 || load_stall_cycles > 3 ||
        flush_cycles < 1 || flush_cycles > 3) begin : g_param_check
        $error("if_id_hazard_controller: parameter out of legal range");
    end

    // Extra cycles spent in LOAD_STALL/FLUSH after the triggering cycle.
    localparam logic [1:0] STALL_RELOAD = 2'(load_stall_cycles - 1);
    localparam logic [1:0] FLUSH_RELOAD = 2'(flush_cycles - 1);

    hazard_state_t       state, state_n;
    logic [1:0]          cnt, cnt_n;
    logic [reg_bits-1:0] rs1, rs2, rd;
    logic                load_use;
    logic                pc_we, id_we, flush_pc, flush_nop, bubble, flush_evt;

    assign rs1 = hz.id_rs1;
    assign rs2 = hz.id_rs2;
    assign rd  = hz.ex_rd;

    assign load_use = hz.ex_mem_read && (rd != '0) &&
                      ((hz.id_uses_rs1 && (rd == rs1)) || (hz.id_uses_rs2 && (rd == rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pc_we     = 1'b0;
        id_we     = 1'b0;
        flush_pc  = 1'b0;
        flush_nop = 1'b0;
        bubble    = 1'b0;
        flush_evt = 1'b0;

        // A resolved branch outranks everything except an outstanding imem wait.
        if (hz.ex_branch_taken && (state != MEM_WAIT)) begin
            pc_we     = 1'b1;
            id_we     = 1'b1;
            flush_pc  = 1'b1;
            flush_nop = 1'b1;
            bubble    = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_RELOAD != 2'd0) begin
                state_n = FLUSH;
                cnt_n   = FLUSH_RELOAD;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!hz.imem_ready) begin
                        bubble  = 1'b1;
                        state_n = MEM_WAIT;
                    end else if (load_use) begin
                        bubble = 1'b1;
                        if (STALL_RELOAD != 2'd0) begin
                            state_n = LOAD_STALL;
                            cnt_n   = STALL_RELOAD;
                        end
                    end else begin
                        pc_we = 1'b1;
                        id_we = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    bubble = 1'b1;
                    if (cnt == 2'd1) state_n = RUN;
                    else             cnt_n   = cnt - 2'd1;
                end
                FLUSH: begin
                    pc_we     = 1'b1;
                    id_we     = 1'b1;
                    flush_nop = 1'b1;
                    bubble    = 1'b1;
                    if (cnt == 2'd1) state_n = RUN;
                    else             cnt_n   = cnt - 2'd1;
                end
                MEM_WAIT: begin
                    if (hz.ex_branch_taken) begin
                        pc_we     = 1'b1;
                        id_we     = 1'b1;
                        flush_pc  = 1'b1;
                        flush_nop = 1'b1;
                        bubble    = 1'b1;
                        flush_evt = 1'b1;
                        if (hz.imem_ready) begin
                            if (FLUSH_RELOAD != 2'd0) begin
                                state_n = FLUSH;
                                cnt_n   = FLUSH_RELOAD;
                            end else begin
                                state_n = RUN;
                            end
                        end
                    end else if (hz.imem_ready) begin
                        pc_we   = 1'b1;
                        id_we   = 1'b1;
                        state_n = RUN;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    // Controls are forced low for the whole time rst_n is asserted.
    assign hz.pc_write_enable    = rst_n & pc_we;
    assign hz.pc_write_id_enable = rst_n & id_we;
    assign hz.flush_pc_enable    = rst_n & flush_pc;
    assign hz.flush_adder_enable = rst_n & flush_nop;
    assign hz.id_ex_bubble       = rst_n & bubble;
    assign hz.busy               = rst_n & (state != RUN);

    sat_counter #(.width(cnt_bits)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & ~pc_we),
        .count (hz.stall_count)
    );

    sat_counter #(.width(cnt_bits)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & flush_evt),
        .count (hz.flush_count)
    );

endmodule

// File: tb/tb_if_id_hazard_controller.sv
// Bench for if_id_hazard_controller: two configurations driven in lockstep, each checked
// every cycle against a behavioural model, plus directed literal expectations.
module tb_if_id_hazard_controller;

    typedef struct packed {
        logic pcw, idw, fpc, fadd, bub, busy;
    } sig_t;

    typedef struct {
        int stall_left;
        int flush_left;
        bit waiting;
        int stalls;
        int flushes;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1, rs2, exrd;
    logic       u1, u2, mr, bt, rdy;

    int n_chk  = 0;
    int n_fail = 0;

    mdl_t m0, m1;

    always #5 clk = ~clk;

    if_id_hazard_controller_if #(.reg_bits(5), .cnt_bits(16)) i0 ();
    if_id_hazard_controller_if #(.reg_bits(5), .cnt_bits(4))  i1 ();

    assign i0.id_rs1 = rs1;  assign i1.id_rs1 = rs1;
    assign i0.id_rs2 = rs2;  assign i1.id_rs2 = rs2;
    assign i0.id_uses_rs1 = u1;  assign i1.id_uses_rs1 = u1;
    assign i0.id_uses_rs2 = u2;  assign i1.id_uses_rs2 = u2;
    assign i0.ex_rd = exrd;  assign i1.ex_rd = exrd;
    assign i0.ex_mem_read = mr;  assign i1.ex_mem_read = mr;
    assign i0.ex_branch_taken = bt;  assign i1.ex_branch_taken = bt;
    assign i0.imem_ready = rdy;  assign i1.imem_ready = rdy;

    // Config A: two-bubble load-use, two-cycle flush, wide counters.
    if_id_hazard_controller #(
        .data_bits(32), .reg_bits(5), .load_stall_cycles(2), .flush_cycles(2), .cnt_bits(16)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (i0.slave)
    );

    // Config B: single-bubble load-use, three-cycle flush, 4-bit counters.
    if_id_hazard_controller #(
        .data_bits(32), .reg_bits(5), .load_stall_cycles(1), .flush_cycles(3), .cnt_bits(4)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (i1.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int cmax);
        return (v < cmax) ? v + 1 : v;
    endfunction

    // What the outputs must be this cycle, and the bookkeeping for the next cycle.
    function automatic sig_t model_step(input int lsc, input int fc, input int cmax,
                                        input mdl_t m, input bit br, input bit ready,
                                        input bit lu, output mdl_t nm);
        sig_t e;
        e  = '0;
        nm = m;
        e.busy = m.waiting || (m.flush_left > 0) || (m.stall_left > 0);
        if (m.waiting) begin
            if (br) begin
                e.pcw = 1; e.idw = 1; e.fpc = 1; e.fadd = 1; e.bub = 1;
                nm.flushes = sat_inc(m.flushes, cmax);
                if (ready) begin
                    nm.waiting    = 0;
                    nm.flush_left = fc - 1;
                end
            end else if (ready) begin
                e.pcw = 1; e.idw = 1;
                nm.waiting = 0;
            end else begin
                e.bub = 1;
            end
        end else if (br) begin
            e.pcw = 1; e.idw = 1; e.fpc = 1; e.fadd = 1; e.bub = 1;
            nm.flushes    = sat_inc(m.flushes, cmax);
            nm.flush_left = fc - 1;
            nm.stall_left = 0;
        end else if (m.flush_left > 0) begin
            e.pcw = 1; e.idw = 1; e.fadd = 1; e.bub = 1;
            nm.flush_left = m.flush_left - 1;
        end else if (m.stall_left > 0) begin
            e.bub = 1;
            nm.stall_left = m.stall_left - 1;
        end else if (!ready) begin
            e.bub = 1;
            nm.waiting = 1;
        end else if (lu) begin
            e.bub = 1;
            nm.stall_left = lsc - 1;
        end else begin
            e.pcw = 1; e.idw = 1;
        end
        if (!e.pcw) nm.stalls = sat_inc(m.stalls, cmax);
        return e;
    endfunction

    task automatic cmp_all(input string tag, input sig_t a, input sig_t e,
                           input int as, input int es, input int af, input int ef);
        chk({tag, ".pc_write_enable"},    a.pcw,  e.pcw);
        chk({tag, ".pc_write_id_enable"}, a.idw,  e.idw);
        chk({tag, ".flush_pc_enable"},    a.fpc,  e.fpc);
        chk({tag, ".flush_adder_enable"}, a.fadd, e.fadd);
        chk({tag, ".id_ex_bubble"},       a.bub,  e.bub);
        chk({tag, ".busy"},               a.busy, e.busy);
        chk({tag, ".stall_count"},        as,     es);
        chk({tag, ".flush_count"},        af,     ef);
    endtask

    always @(negedge clk) begin
        sig_t a0, a1, e0, e1;
        mdl_t n0, n1;
        bit   lu;
        a0 = {i0.pc_write_enable, i0.pc_write_id_enable, i0.flush_pc_enable,
              i0.flush_adder_enable, i0.id_ex_bubble, i0.busy};
        a1 = {i1.pc_write_enable, i1.pc_write_id_enable, i1.flush_pc_enable,
              i1.flush_adder_enable, i1.id_ex_bubble, i1.busy};
        if (!rst_n) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
            cmp_all("rst0", a0, '0, int'(i0.stall_count), 0, int'(i0.flush_count), 0);
            cmp_all("rst1", a1, '0, int'(i1.stall_count), 0, int'(i1.flush_count), 0);
        end else begin
            lu = mr && (exrd != 0) && ((u1 && exrd == rs1) || (u2 && exrd == rs2));
            e0 = model_step(2, 2, 65535, m0, bt, rdy, lu, n0);
            e1 = model_step(1, 3, 15, m1, bt, rdy, lu, n1);
            cmp_all("dut0", a0, e0, int'(i0.stall_count), m0.stalls, int'(i0.flush_count), m0.flushes);
            cmp_all("dut1", a1, e1, int'(i1.stall_count), m1.stalls, int'(i1.flush_count), m1.flushes);
            m0 = n0;
            m1 = n1;
        end
    end

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; exrd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0; bt = 1'b0; rdy = 1'b1;
    endtask

    task automatic set_load_use();
        mr = 1'b1; exrd = 5'd5; rs2 = 5'd5; u2 = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        #1;
        chk("reset_pcw0", i0.pc_write_enable, 0);
        chk("reset_busy1", i1.busy, 0);
        chk("reset_stall0", int'(i0.stall_count), 0);
        rst_n = 1'b1;
        #1;
        chk("release_pcw0", i0.pc_write_enable, 1);
        tick();
        tick();

        // Load-use on rs2: config A stalls two cycles, config B one.
        set_load_use();
        #1;
        chk("lu_c0_pcw0", i0.pc_write_enable, 0);
        chk("lu_c0_bub0", i0.id_ex_bubble, 1);
        chk("lu_c0_pcw1", i1.pc_write_enable, 0);
        tick();
        idle();
        #1;
        chk("lu_c1_pcw0", i0.pc_write_enable, 0);
        chk("lu_c1_busy0", i0.busy, 1);
        chk("lu_c1_pcw1", i1.pc_write_enable, 1);
        tick();
        #1;
        chk("lu_c2_pcw0", i0.pc_write_enable, 1);
        chk("lu_stall0", int'(i0.stall_count), 2);
        chk("lu_stall1", int'(i1.stall_count), 1);
        tick();

        // x0 destination never stalls.
        mr = 1'b1; exrd = 5'd0; rs1 = 5'd0; u1 = 1'b1;
        #1;
        chk("rd0_pcw0", i0.pc_write_enable, 1);
        tick();
        idle();
        #1;
        chk("rd0_stall0", int'(i0.stall_count), 2);

        // Taken-branch pulse.
        bt = 1'b1;
        #1;
        chk("br_c0_fpc0", i0.flush_pc_enable, 1);
        chk("br_c0_fadd0", i0.flush_adder_enable, 1);
        tick();
        bt = 1'b0;
        #1;
        chk("br_c1_fpc0", i0.flush_pc_enable, 0);
        chk("br_c1_fadd0", i0.flush_adder_enable, 1);
        tick();
        #1;
        chk("br_c2_fadd0", i0.flush_adder_enable, 0);
        chk("br_c2_fadd1", i1.flush_adder_enable, 1);
        chk("br_flush0", int'(i0.flush_count), 1);
        tick();
        tick();

        // imem wait for three cycles with a load-use pending throughout.
        set_load_use();
        rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        tick();
        tick();
        idle();
        #1;
        chk("mw_lu_stall1", int'(i1.stall_count), 5);
        tick();
        #1;
        chk("mw_lu_stall0", int'(i0.stall_count), 7);

        // Branch resolved while waiting on imem.
        rdy = 1'b0;
        tick();
        bt = 1'b1;
        #1;
        chk("mwbr_fpc0", i0.flush_pc_enable, 1);
        chk("mwbr_pcw0", i0.pc_write_enable, 1);
        chk("mwbr_busy0", i0.busy, 1);
        tick();
        bt = 1'b0;
        rdy = 1'b1;
        #1;
        chk("mwbr_resume_pcw0", i0.pc_write_enable, 1);
        chk("mwbr_resume_fadd0", i0.flush_adder_enable, 0);
        tick();
        #1;
        chk("mwbr_flush0", int'(i0.flush_count), 2);

        // Branch preempting a load stall, then a back-to-back branch restarting the flush.
        set_load_use();
        tick();
        idle();
        bt = 1'b1;
        tick();
        tick();
        bt = 1'b0;
        repeat (4) tick();

        // Long imem stall drives the 4-bit counter into saturation.
        rdy = 1'b0;
        repeat (21) tick();
        rdy = 1'b1;
        #1;
        chk("sat_stall1", int'(i1.stall_count), 15);
        tick();
        tick();

        // Asynchronous reset during the second cycle of a three-cycle flush.
        bt = 1'b1;
        tick();
        bt = 1'b0;
        #1;
        chk("rf_busy1_before", i1.busy, 1);
        chk("rf_fadd1_before", i1.flush_adder_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("rf_pcw1", i1.pc_write_enable, 0);
        chk("rf_idw1", i1.pc_write_id_enable, 0);
        chk("rf_fadd1", i1.flush_adder_enable, 0);
        chk("rf_bub1", i1.id_ex_bubble, 0);
        chk("rf_busy1", i1.busy, 0);
        chk("rf_stall1", int'(i1.stall_count), 0);
        chk("rf_flush1", int'(i1.flush_count), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rf_release_pcw1", i1.pc_write_enable, 1);
        chk("rf_release_busy1", i1.busy, 0);
        chk("rf_release_fadd1", i1.flush_adder_enable, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_controller.md
Name: if_id_hazard_controller

Overview:
- Sequences the IF stage and the IF/ID pipeline register of the 5-stage RISC-V core: generates PC write enable, IF/ID write enable, branch-redirect select and IF/ID flush.
- Detects load-use hazards, taken branches/jumps and instruction-memory wait states. Holds multi-cycle stalls/flushes in a small FSM.
- Keeps saturating stall/flush performance counters. Sits between ID/EX decode outputs and the IF/PC/IF-ID registers.

Parameters:
- data_bits, 32, width of PC-side datapath (counters do not depend on it)
- reg_bits, 5, register index width
- load_stall_cycles, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal 1..3
- flush_cycles, 1, cycles IF/ID is flushed after a taken branch; legal 1..3
- cnt_bits, 16, width of performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  reg_bits  rs1 index of instruction in ID
- id_rs2  in  reg_bits  rs2 index of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  reg_bits  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved taken branch/jump this cycle
- imem_ready  in  1  instruction memory returns valid data this cycle
- pc_write_enable  out  1  PC register may update
- pc_write_id_enable  out  1  IF/ID register captures PC/instruction
- flush_pc_enable  out  1  PC mux selects branch target
- flush_adder_enable  out  1  IF/ID instruction replaced by NOP (0x00000013)
- id_ex_bubble  out  1  ID/EX control fields zeroed
- busy  out  1  FSM not in RUN
- stall_count  out  cnt_bits  cycles with pc_write_enable low
- flush_count  out  cnt_bits  taken-branch flush events

Behaviour:
- States: RUN, LOAD_STALL, FLUSH, MEM_WAIT. State and counters registered; control outputs combinational from state plus inputs (same-cycle response required).
- rst_n low (async): state RUN, internal down-counter 0, stall_count/flush_count 0. While rst_n low all control outputs 0 and busy 0.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- Priority in RUN: ex_branch_taken > !imem_ready > load_use > normal.
- RUN normal: pc_write_enable=1, pc_write_id_enable=1, others 0.
- RUN + ex_branch_taken: flush_pc_enable=1, pc_write_enable=1, pc_write_id_enable=1, flush_adder_enable=1, id_ex_bubble=1. flush_count++. If flush_cycles>1 go FLUSH with counter=flush_cycles-1, else stay RUN.
- RUN + !imem_ready: pc_write_enable=0, pc_write_id_enable=0, id_ex_bubble=1. Go MEM_WAIT.
- RUN + load_use: pc_write_enable=0, pc_write_id_enable=0, id_ex_bubble=1. If load_stall_cycles>1 go LOAD_STALL with counter=load_stall_cycles-1.
- LOAD_STALL: same outputs as load-use cycle. Counter decrements; at 1 return to RUN. ex_branch_taken here preempts: branch outputs, go RUN/FLUSH.
- FLUSH: pc_write_enable=1, pc_write_id_enable=1, flush_adder_enable=1, id_ex_bubble=1, flush_pc_enable=0. Counter decrements; at 1 return to RUN. A new ex_branch_taken restarts the flush (flush_pc_enable=1, counter reloaded, flush_count++).
- MEM_WAIT: PC and IF/ID frozen, id_ex_bubble=1. When imem_ready=1: outputs as RUN normal, next RUN. ex_branch_taken in MEM_WAIT: flush_pc_enable=1, pc_write_enable=1, IF/ID flushed, flush_count++, stay MEM_WAIT if imem_ready=0.
- stall_count increments every cycle pc_write_enable=0 (rst_n high). Both counters saturate at all-ones, no wrap.
- busy=1 in LOAD_STALL, FLUSH, MEM_WAIT.
- ex_rd==0 never causes a stall.

Decomposition:
- Shared package core_ctrl_pkg: state enum hazard_state_t (RUN, LOAD_STALL, FLUSH, MEM_WAIT), constant NOP_INSTR=32'h00000013.
- One sub-module: sat_counter (parameter width, inc, async rst_n, saturating), instantiated twice.

Test Plan:
- Reset mid-FLUSH (flush_cycles=3, drop rst_n in 2nd flush cycle) -> state RUN, counters 0, all controls 0 immediately, normal run after release.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, load_stall_cycles=2 -> pc_write_enable=0 and id_ex_bubble=1 for exactly 2 cycles; stall_count=2.
- ex_rd=0 with matching id_rs1=0 and ex_mem_read=1 -> no stall, stall_count unchanged.
- ex_branch_taken pulse, flush_cycles=2 -> cycle 0 flush_pc_enable=1 and flush_adder_enable=1; cycle 1 flush_adder_enable=1 only; flush_count=1.
- imem_ready low 3 cycles while load_use also true -> 3 frozen cycles in MEM_WAIT, then 1 load-use stall; stall_count=4.
- Force 2^cnt_bits+5 stall cycles (cnt_bits=4) -> stall_count holds 15.
